// File: rtl/pipe_stage_skid_reg.sv
// Generic pipeline stage register: valid/ready handshake, 2-entry skid
// buffer, flush-to-bubble, control field split from data.
// Ports: clk_i, rst_i (sync, active-high), flush_i;
//   upstream valid_i/ready_o/data_i/ctrl_i;
//   downstream valid_o/ready_i/data_o/ctrl_o.
// Optional PIPE_STAGE_PERF_EN: adds stall_cnt_o/flush_cnt_o (saturating).
module pipe_stage_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  logic xfer_in;
  logic xfer_out;
  logic ld_main_in;
  logic ld_main_skid;
  logic ld_skid;
  logic clr_ctrl;

  assign xfer_in  = valid_i & ready_o;
  assign xfer_out = valid_o & ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (valid_i) state_nxt = ONE;
        ONE: begin
          if (xfer_in && !xfer_out)
            state_nxt = FULL;
          else if (!xfer_in && xfer_out)
            state_nxt = EMPTY;
        end
        FULL: if (xfer_out) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // ready_o/valid_o come straight from the state register, so there is
  // no combinational path from ready_i to ready_o.
  always_comb begin
    ready_o      = (state != FULL);
    valid_o      = (state != EMPTY);
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    clr_ctrl     = flush_i;
    if (!flush_i) begin
      unique case (state)
        EMPTY: ld_main_in = valid_i;
        ONE: begin
          ld_main_in = xfer_in & xfer_out;
          ld_skid    = xfer_in & ~xfer_out;
          clr_ctrl   = ~xfer_in & xfer_out;
        end
        FULL: ld_main_skid = xfer_out;
        default: clr_ctrl = 1'b1;
      endcase
    end
  end

  // main_ctrl is zeroed whenever the stage goes empty, so ctrl_o is a
  // plain register that already reads 0 while invalid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      if (ld_main_in) begin
        main_data <= data_i;
        main_ctrl <= ctrl_i;
      end else if (ld_main_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end else if (clr_ctrl) begin
        main_ctrl <= '0;
      end
      if (ld_skid) begin
        skid_data <= data_i;
        skid_ctrl <= ctrl_i;
      end
    end
  end

  assign data_o = main_data;
  assign ctrl_o = main_ctrl;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (valid_o && !ready_i && !flush_i
          && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (flush_i && state != EMPTY
          && flush_cnt != 32'hFFFF_FFFF)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: directed beats are queued on
// issue, a negedge monitor pops and compares every downstream transfer.
module tb_pipe_stage_skid_reg;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] data_i = '0;
  logic [7:0]  ctrl_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] data_o;
  logic [7:0]  ctrl_o;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.DATA_W(32), .CTRL_W(8)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .ctrl_i  (ctrl_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .ctrl_o  (ctrl_o)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [39:0] exp_q[$];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  nm, got, exp);
  endtask

  // Apply inputs, let one rising edge sample them, return 1 time unit
  // after the edge so outputs reflect that edge.
  task automatic step(input logic v,
                      input logic [31:0] d,
                      input logic [7:0] c,
                      input logic rdy,
                      input logic fl,
                      input logic rs);
    valid_i = v;
    data_i  = d;
    ctrl_i  = c;
    ready_i = rdy;
    flush_i = fl;
    rst_i   = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d,
                      input logic [7:0] c);
    exp_q.push_back({c, d});
  endtask

  // Monitor: inputs and outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_beat: got %h/%h expected none",
                   data_o, ctrl_o);
        end else begin
          logic [39:0] e;
          e = exp_q.pop_front();
          chk("beat_data", data_o, e[31:0]);
          chk("beat_ctrl", {24'd0, ctrl_o}, {24'd0, e[39:32]});
        end
      end
      if (!valid_o)
        chk("ctrl_zero_idle", {24'd0, ctrl_o}, 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_data", data_o, 32'd0);
    chk("rst_ctrl", {24'd0, ctrl_o}, 32'd0);

    // 1: streaming, one-cycle latency
    push(32'h100, 8'h81);
    step(1, 32'h100, 8'h81, 1, 0, 0);
    chk("lat_valid", {31'd0, valid_o}, 32'd1);
    chk("lat_data", data_o, 32'h100);
    chk("s1_ready_a", {31'd0, ready_o}, 32'd1);
    push(32'h104, 8'h81);
    step(1, 32'h104, 8'h81, 1, 0, 0);
    chk("s1_ready_b", {31'd0, ready_o}, 32'd1);
    push(32'h108, 8'h81);
    step(1, 32'h108, 8'h81, 1, 0, 0);
    chk("s1_ready_c", {31'd0, ready_o}, 32'd1);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("drain_valid", {31'd0, valid_o}, 32'd0);
    chk("drain_data_kept", data_o, 32'h108);

    // 2: backpressure into skid
    push(32'h10, 8'h11);
    step(1, 32'h10, 8'h11, 0, 0, 0);
    push(32'h20, 8'h22);
    step(1, 32'h20, 8'h22, 0, 0, 0);
    chk("full_ready", {31'd0, ready_o}, 32'd0);
    chk("full_head", data_o, 32'h10);
    step(0, 0, 0, 1, 0, 0);
    chk("after_a_ready", {31'd0, ready_o}, 32'd1);
    chk("after_a_data", data_o, 32'h20);
    step(0, 0, 0, 1, 0, 0);
    chk("after_b_valid", {31'd0, valid_o}, 32'd0);

    // 3: flush while FULL
    step(1, 32'h30, 8'h33, 0, 0, 0);
    step(1, 32'h40, 8'h44, 0, 0, 0);
    chk("pre_flush_ready", {31'd0, ready_o}, 32'd0);
    step(0, 0, 0, 0, 1, 0);
    chk("fl_valid", {31'd0, valid_o}, 32'd0);
    chk("fl_ctrl", {24'd0, ctrl_o}, 32'd0);
    chk("fl_ready", {31'd0, ready_o}, 32'd1);
`ifdef PIPE_STAGE_PERF_EN
    chk("fl_cnt", flush_cnt_o, 32'd1);
`endif
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    // 4: flush beats a same-cycle input in EMPTY
    step(1, 32'h55, 8'h05, 1, 1, 0);
    chk("fl_in_valid", {31'd0, valid_o}, 32'd0);
    step(0, 0, 0, 1, 0, 0);
    chk("fl_in_valid2", {31'd0, valid_o}, 32'd0);
`ifdef PIPE_STAGE_PERF_EN
    chk("fl_cnt_empty", flush_cnt_o, 32'd1);
`endif

    // 5: reset + flush while FULL
    step(1, 32'h60, 8'h66, 0, 0, 0);
    step(1, 32'h61, 8'h67, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("rf_valid", {31'd0, valid_o}, 32'd0);
    chk("rf_ready", {31'd0, ready_o}, 32'd1);
    chk("rf_data", data_o, 32'd0);
    chk("rf_ctrl", {24'd0, ctrl_o}, 32'd0);
`ifdef PIPE_STAGE_PERF_EN
    chk("rf_stall", stall_cnt_o, 32'd0);
    chk("rf_flush", flush_cnt_o, 32'd0);
`endif
    push(32'h77, 8'h07);
    step(1, 32'h77, 8'h07, 1, 0, 0);
    chk("post_rst_data", data_o, 32'h77);
    step(0, 0, 0, 1, 0, 0);

`ifdef PIPE_STAGE_PERF_EN
    // 6: stall counter and saturation
    push(32'h90, 8'h09);
    step(1, 32'h90, 8'h09, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
    chk("stall5", stall_cnt_o, 32'd5);
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    chk("stall_sat", stall_cnt_o, 32'hFFFF_FFFF);
    step(0, 0, 0, 1, 0, 0);
`endif

    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
